// File: rtl/counter_mod.sv
// counter_mod
//
// Parametrised synchronous modulo counter covering 0..MAX. It supports up/down
// counting, count enable, parallel load (clamped to MAX), synchronous clear,
// and either wrap or saturate behaviour at the boundaries. It also provides a
// combinational terminal-count flag and a sticky overflow flag.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MAX      : terminal (largest) count value, 1 <= MAX <= 2^WIDTH-1
//   SATURATE : 0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset
//   clr      : synchronous clear of count, wrap and ovf
//   load     : parallel load of load_val (clamped to MAX)
//   load_val : value to load
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   count    : current count (registered)
//   tc       : next enabled edge hits the boundary (combinational)
//   wrap     : one-cycle pulse while count shows a wrapped value (registered)
//   ovf      : sticky overflow/underflow flag (registered)
//
// Priority per edge: rst low > clr > load > en.

module counter_mod #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned MAX      = 63,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

    logic at_max;
    logic at_zero;

    // Boundaries are judged against MAX, never against the all-ones value.
    assign at_max  = (count == MAX_V);
    assign at_zero = (count == '0);

    // tc is usable as a carry-enable into a cascaded stage, so it must be
    // suppressed whenever this edge will not actually count.
    always_comb begin
        tc = rst & en & ~clr & ~load & ((up & at_max) | (~up & at_zero));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= (load_val > MAX_V) ? MAX_V : load_val;
            wrap  <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    count <= count + WIDTH'(1);
                    wrap  <= 1'b0;
                end else begin
                    ovf <= 1'b1;
                    if (SATURATE) begin
                        wrap <= 1'b0;
                    end else begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end
                end
            end else begin
                if (!at_zero) begin
                    count <= count - WIDTH'(1);
                    wrap  <= 1'b0;
                end else begin
                    ovf <= 1'b1;
                    if (SATURATE) begin
                        wrap <= 1'b0;
                    end else begin
                        count <= MAX_V;
                        wrap  <= 1'b1;
                    end
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
module tb_counter_mod;

    typedef struct {
        int         id;
        string      nm;
        logic       etc;
        logic [7:0] ecnt;
        logic       ew;
        logic       eo;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // per-DUT stimulus: 0 = W6/M39 wrap, 1 = W6/M39 saturate,
    // 2 = W4/M15 wrap, 3 = cascaded pair of W4/M15 (8-bit)
    logic       rst_v [4];
    logic       clr_v [4];
    logic       ld_v  [4];
    logic [7:0] lv_v  [4];
    logic       en_v  [4];
    logic       up_v  [4];

    logic [5:0] c0, c1;
    logic [3:0] c2, c3l, c3h;
    logic tc0, tc1, tc2, tc3l, tc3h;
    logic w0, w1, w2, w3l, w3h;
    logic o0, o1, o2, o3l, o3h;

    counter_mod #(.WIDTH(6), .MAX(39), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst_v[0]), .clr(clr_v[0]), .load(ld_v[0]), .load_val(lv_v[0][5:0]),
        .en(en_v[0]), .up(up_v[0]), .count(c0), .tc(tc0), .wrap(w0), .ovf(o0));

    counter_mod #(.WIDTH(6), .MAX(39), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst(rst_v[1]), .clr(clr_v[1]), .load(ld_v[1]), .load_val(lv_v[1][5:0]),
        .en(en_v[1]), .up(up_v[1]), .count(c1), .tc(tc1), .wrap(w1), .ovf(o1));

    counter_mod #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u2 (
        .clk(clk), .rst(rst_v[2]), .clr(clr_v[2]), .load(ld_v[2]), .load_val(lv_v[2][3:0]),
        .en(en_v[2]), .up(up_v[2]), .count(c2), .tc(tc2), .wrap(w2), .ovf(o2));

    counter_mod #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u3l (
        .clk(clk), .rst(rst_v[3]), .clr(clr_v[3]), .load(ld_v[3]), .load_val(lv_v[3][3:0]),
        .en(en_v[3]), .up(up_v[3]), .count(c3l), .tc(tc3l), .wrap(w3l), .ovf(o3l));

    counter_mod #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u3h (
        .clk(clk), .rst(rst_v[3]), .clr(clr_v[3]), .load(ld_v[3]), .load_val(lv_v[3][7:4]),
        .en(tc3l), .up(up_v[3]), .count(c3h), .tc(tc3h), .wrap(w3h), .ovf(o3h));

    logic [7:0] a_cnt [4];
    logic       a_tc  [4];
    logic       a_w   [4];
    logic       a_o   [4];

    assign a_cnt[0] = {2'b00, c0};
    assign a_cnt[1] = {2'b00, c1};
    assign a_cnt[2] = {4'h0, c2};
    assign a_cnt[3] = {c3h, c3l};
    assign a_tc[0] = tc0;
    assign a_tc[1] = tc1;
    assign a_tc[2] = tc2;
    assign a_tc[3] = tc3h;
    assign a_w[0] = w0;
    assign a_w[1] = w1;
    assign a_w[2] = w2;
    assign a_w[3] = w3h;
    assign a_o[0] = o0;
    assign a_o[1] = o1;
    assign a_o[2] = o2;
    assign a_o[3] = o3h;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic busy   = 1'b0;

    // Drive one cycle of stimulus for DUT 'id' (others idle) and queue what
    // that cycle must show: tc before the edge, count/wrap/ovf after it.
    task automatic step(input int id, input string nm,
                        input logic r, input logic c, input logic l, input logic [7:0] lv,
                        input logic e, input logic u,
                        input logic xtc, input logic [7:0] xc, input logic xw, input logic xo);
        exp_t x;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1; clr_v[k] = 1'b0; ld_v[k] = 1'b0;
            lv_v[k]  = 8'h00; en_v[k] = 1'b0; up_v[k] = 1'b0;
        end
        rst_v[id] = r; clr_v[id] = c; ld_v[id] = l;
        lv_v[id]  = lv; en_v[id] = e; up_v[id] = u;
        x.id = id; x.nm = nm; x.etc = xtc; x.ecnt = xc; x.ew = xw; x.eo = xo;
        q.push_back(x);
    endtask

    // Monitor: pops one expectation per cycle, checks tc mid-cycle and the
    // registered outputs just after the following edge.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur  = q.pop_front();
                busy = 1'b1;
                checks++;
                if (a_tc[cur.id] !== cur.etc) begin
                    errors++;
                    $display("FAIL %s tc: got %0b want %0b", cur.nm, a_tc[cur.id], cur.etc);
                end
                @(posedge clk);
                #2;
                checks++;
                if (a_cnt[cur.id] !== cur.ecnt) begin
                    errors++;
                    $display("FAIL %s count: got %0d want %0d", cur.nm, a_cnt[cur.id], cur.ecnt);
                end
                checks++;
                if (a_w[cur.id] !== cur.ew) begin
                    errors++;
                    $display("FAIL %s wrap: got %0b want %0b", cur.nm, a_w[cur.id], cur.ew);
                end
                checks++;
                if (a_o[cur.id] !== cur.eo) begin
                    errors++;
                    $display("FAIL %s ovf: got %0b want %0b", cur.nm, a_o[cur.id], cur.eo);
                end
                busy = 1'b0;
            end
        end
    end

    initial begin
        int  pre;
        bit  drained;
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b0; clr_v[k] = 1'b0; ld_v[k] = 1'b0;
            lv_v[k]  = 8'h00; en_v[k] = 1'b0; up_v[k] = 1'b0;
        end
        repeat (2) @(posedge clk);

        // reset holds everything at zero even with en/up asserted
        step(0, "reset", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // wrap up: 0..39 then 0..5, wrap on return to 0, ovf sticky
        for (int i = 0; i < 45; i++)
            step(0, "wrap_up", 1, 0, 0, 0, 1, 1,
                 (i % 40) == 39, 8'((i + 1) % 40), ((i + 1) % 40) == 0, i >= 39);

        // load clamp, then clr beats load
        step(0, "clamp",    1, 0, 1, 50, 1, 1, 0, 39, 0, 1);
        step(0, "clr_load", 1, 1, 1, 5,  1, 1, 0, 0,  0, 0);

        // direction change at the boundary
        step(0, "dir_load39", 1, 0, 1, 39, 0, 0, 0, 39, 0, 0);
        step(0, "dir_down",   1, 0, 0, 0,  1, 0, 0, 38, 0, 0);
        step(0, "dir_up1",    1, 0, 0, 0,  1, 1, 0, 39, 0, 0);
        step(0, "dir_up2",    1, 0, 0, 0,  1, 1, 1, 0,  1, 1);

        // reset mid-operation overrides load/en
        step(0, "mid_load17", 1, 0, 1, 17, 0, 0, 0, 17, 0, 1);
        step(0, "mid_rst",    0, 0, 1, 9,  1, 1, 0, 0,  0, 0);
        step(0, "resume",     1, 0, 0, 0,  1, 1, 0, 1,  0, 0);
        step(0, "hold",       1, 0, 0, 0,  0, 1, 0, 1,  0, 0);
        step(0, "down",       1, 0, 0, 0,  1, 0, 0, 0,  0, 0);
        step(0, "down_wrap",  1, 0, 0, 0,  1, 0, 1, 39, 1, 1);
        step(0, "wrap_end",   1, 0, 0, 0,  0, 0, 0, 39, 0, 1);

        // saturate down from 3: 2,1,0,0,0,0 with no wrap
        step(1, "sat_load3", 1, 0, 1, 3, 0, 0, 0, 3, 0, 0);
        for (int i = 0; i < 6; i++)
            step(1, "sat_down", 1, 0, 0, 0, 1, 0,
                 i >= 3, 8'((i < 3) ? (2 - i) : 0), 0, i >= 3);
        step(1, "sat_clamp", 1, 0, 1, 60, 1, 1, 0, 39, 0, 1);
        step(1, "sat_up",    1, 0, 0, 0,  1, 1, 1, 39, 0, 1);

        // full-range 4-bit rollover every 16 cycles
        for (int i = 0; i < 34; i++)
            step(2, "full_roll", 1, 0, 0, 0, 1, 1,
                 (i % 16) == 15, 8'((i + 1) % 16), ((i + 1) % 16) == 0, i >= 15);

        // cascaded pair: 8-bit count through 255 -> 0
        step(3, "cas_clr",  1, 1, 0, 0,   0, 0, 0, 0,   0, 0);
        step(3, "cas_load", 1, 0, 1, 250, 0, 0, 0, 250, 0, 0);
        for (int i = 0; i < 8; i++) begin
            pre = 250 + i;
            step(3, "cascade", 1, 0, 0, 0, 1, 1,
                 pre == 255, 8'((pre + 1) % 256), ((pre + 1) % 256) == 0, pre >= 255);
        end

        drained = 1'b0;
        for (int n = 0; n < 20 && !drained; n++) begin
            @(posedge clk);
            #3;
            if (q.size() == 0 && !busy) drained = 1'b1;
        end
        if (!drained) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised synchronous modulo counter. It replaces the fixed 6-bit toggle-chain counter in the CPU datapath and timing logic. It adds configurable width and terminal value, up/down counting, count enable, parallel load, synchronous clear, wrap-or-saturate mode, a terminal-count flag, and a sticky overflow flag. It is used wherever a bounded index or cycle counter is needed, for example board row/column scanning or multi-cycle operation sequencing.

## Interface
- WIDTH, 6: counter width in bits; legal range 2..32.
- MAX, 63: terminal (largest) count value; 1 <= MAX <= 2^WIDTH-1.
- SATURATE, 0: 0 = wrap at terminal value; 1 = hold at terminal value.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-low reset, sampled on rising clk.
- clr  input  1  synchronous clear of count and ovf.
- load  input  1  parallel load of load_val.
- load_val  input  WIDTH  value to load; clamped to MAX.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count; combinational.
- wrap  output  1  one-cycle pulse, registered.
- ovf  output  1  sticky overflow/underflow flag, registered.

## Operation
- Per-edge priority, highest first: rst low > clr > load > en. Only one action occurs per edge.
- rst low: count=0, wrap=0, ovf=0.
- clr=1: count=0, wrap=0, ovf=0.
- load=1:
  - count = (load_val > MAX) ? MAX : load_val.
  - wrap=0; ovf is unchanged.
- en=1, up=1:
  - If count < MAX: count+1.
  - If count == MAX and SATURATE=0: count=0, wrap=1, ovf=1.
  - If count == MAX and SATURATE=1: count holds at MAX, wrap=0, ovf=1.
- en=1, up=0:
  - If count > 0: count-1.
  - If count == 0 and SATURATE=0: count=MAX, wrap=1, ovf=1.
  - If count == 0 and SATURATE=1: count holds at 0, wrap=0, ovf=1.
- en=0 with no higher-priority input: count holds, wrap=0, ovf holds.
- tc = en & ~clr & ~load & ((up & count==MAX) | (~up & count==0)).
  - tc is gated by rst high. It flags that the next edge will hit the boundary.
- Count values above MAX are unreachable, because load clamps. The arithmetic never exceeds WIDTH bits; compare against MAX, not 2^WIDTH-1.
- If MAX == 2^WIDTH-1, wrap behaviour is identical to natural binary rollover.
- Direction may change on any cycle. The next edge uses the value of up sampled at that edge.

## Timing
- All state updates occur on the rising clk edge. There are no asynchronous paths from rst.
- count latency: a change appears 1 cycle after the edge sampling en/load/clr.
- wrap: high for exactly one cycle, the cycle in which count shows the wrapped value. Continuous counting with MAX=1 gives a wrap pulse every 2 cycles.
- ovf: sets on the edge of the boundary event and stays set until clr or rst.
- tc: valid in the same cycle as its inputs, with no register stage. Downstream logic may use it as a carry-enable into a cascaded counter_mod.
- Reset mid-count: rst low on any edge forces all outputs to 0 on that edge, regardless of en/load/clr. While rst is low, tc=0.
- After reset deasserts, the first count occurs on the first edge with rst=1 and en=1.

## Test plan
- Wrap up: WIDTH=6, MAX=39, SATURATE=0; reset, then en=1, up=1 for 45 cycles.
  - Required: count 0..39 then 0..4.
  - tc=1 only while count=39 (with en=1, up=1).
  - wrap=1 in exactly the cycle count returns to 0.
  - ovf=1 from then on.
- Saturate down: SATURATE=1, MAX=39; load 3, then en=1, up=0 for 6 cycles.
  - Required: count 3,2,1,0,0,0; wrap never asserts.
  - ovf rises on the edge where count would go below 0.
- Load clamp and priority:
  - load_val=50, MAX=39, load=1, en=1 → count=39.
  - Next edge, clr=1 and load=1 together → count=0, ovf=0.
- Direction change at boundary: MAX=39, count=39, en=1.
  - up=0 → count=38, no wrap.
  - Then up=1 twice → 39, then 0 with wrap=1.
- Reset mid-operation: count=17, ovf=1, en=1, load=1; drive rst=0 for one edge.
  - Required: count=0, wrap=0, ovf=0, tc=0.
  - Resume: with rst=1, en=1 → count=1 next edge.
- Full-range rollover: WIDTH=4, MAX=15; count continuously.
  - Required: 15→0 with wrap=1 every 16 cycles.
  - Two cascaded instances, with the high instance's en = low instance's tc, produce an 8-bit count through 255→0.
